// File: rtl/umi_priority_merge.sv
// Two-input UMI merger: per-channel registered FIFOs feeding a strict-priority
// arbiter (umi0 first) with a starvation limit that guarantees umi1 progress.
module umi_priority_merge #(
    parameter int AW     = 64,
    parameter int UW     = 256,
    parameter int DEPTH  = 4,
    parameter int STARVE = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          umi0_in_valid,
    input  logic [UW-1:0] umi0_in_packet,
    output logic          umi0_in_full,
    input  logic          umi1_in_valid,
    input  logic [UW-1:0] umi1_in_packet,
    output logic          umi1_in_full,
    output logic          umi_out_valid,
    output logic [UW-1:0] umi_out_packet,
    input  logic          umi_out_ready,
    output logic [1:0]    overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

    // The address field rides inside the packet, so it must fit within UW.
    if ((AW < 1) || (AW > UW) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (STARVE < 1)) begin : g_bad_params
        $error("umi_priority_merge: illegal parameter combination");
    end

    logic [UW-1:0] mem_r      [2][DEPTH];
    logic [PW-1:0] wr_ptr_r   [2];
    logic [PW-1:0] rd_ptr_r   [2];
    logic [CW-1:0] count_r    [2];
    logic [UW-1:0] in_packet_s[2];

    logic [1:0]    in_valid_s;
    logic [1:0]    full_s;
    logic [1:0]    empty_s;
    logic [1:0]    push_s;
    logic [1:0]    drop_s;
    logic [1:0]    pop_s;
    logic          sel_s;
    logic          out_valid_s;
    logic          accept_s;
    logic          lock_r;
    logic          lock_sel_r;
    logic [SW-1:0] starve_cnt_r;
    logic [1:0]    overflow_r;

    assign in_valid_s = {umi1_in_valid, umi0_in_valid};

    // Per-channel status, push/drop qualification and packet gathering.
    always_comb begin
        in_packet_s[0] = umi0_in_packet;
        in_packet_s[1] = umi1_in_packet;
        full_s         = 2'b00;
        empty_s        = 2'b00;
        push_s         = 2'b00;
        drop_s         = 2'b00;
        for (int c = 0; c < 2; c++) begin
            full_s[c]  = (count_r[c] == FULL_CNT);
            empty_s[c] = (count_r[c] == {CW{1'b0}});
            push_s[c]  = in_valid_s[c] & ~full_s[c];
            drop_s[c]  = in_valid_s[c] & full_s[c];
        end
    end

    assign out_valid_s = ~empty_s[0] | ~empty_s[1];
    assign accept_s    = out_valid_s & umi_out_ready;

    // Channel selection: a stalled grant stays locked so the presented packet never changes.
    always_comb begin
        sel_s = 1'b0;
        if (lock_r) begin
            sel_s = lock_sel_r;
        end else if (!empty_s[1] && (empty_s[0] || (starve_cnt_r == STARVE_MAX))) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    // Pop the selected channel on an accepted transfer.
    always_comb begin
        pop_s = 2'b00;
        if (accept_s) begin
            pop_s[sel_s] = 1'b1;
        end else begin
            pop_s = 2'b00;
        end
    end

    // FIFO storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (push_s[c] && !reset) begin
                mem_r[c][wr_ptr_r[c]] <= in_packet_s[c];
            end
        end
    end

    // FIFO pointers and occupancy counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                wr_ptr_r[c] <= {PW{1'b0}};
                rd_ptr_r[c] <= {PW{1'b0}};
                count_r[c]  <= {CW{1'b0}};
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push_s[c]) begin
                    wr_ptr_r[c] <= wr_ptr_r[c] + PW'(1);
                end
                if (pop_s[c]) begin
                    rd_ptr_r[c] <= rd_ptr_r[c] + PW'(1);
                end
                case ({push_s[c], pop_s[c]})
                    2'b10:   count_r[c] <= count_r[c] + CW'(1);
                    2'b01:   count_r[c] <= count_r[c] - CW'(1);
                    default: count_r[c] <= count_r[c];
                endcase
            end
        end
    end

    // Grant lock, starvation counter and sticky overflow flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_r       <= 1'b0;
            lock_sel_r   <= 1'b0;
            starve_cnt_r <= {SW{1'b0}};
            overflow_r   <= 2'b00;
        end else begin
            overflow_r <= overflow_r | drop_s;
            if (out_valid_s && !umi_out_ready) begin
                lock_r     <= 1'b1;
                lock_sel_r <= sel_s;
            end else if (accept_s) begin
                lock_r     <= 1'b0;
            end
            if (empty_s[1]) begin
                starve_cnt_r <= {SW{1'b0}};
            end else if (accept_s && sel_s) begin
                starve_cnt_r <= {SW{1'b0}};
            end else if (accept_s && (starve_cnt_r != STARVE_MAX)) begin
                starve_cnt_r <= starve_cnt_r + SW'(1);
            end
        end
    end

    assign umi0_in_full   = full_s[0];
    assign umi1_in_full   = full_s[1];
    assign umi_out_valid  = out_valid_s;
    assign umi_out_packet = sel_s ? mem_r[1][rd_ptr_r[1]] : mem_r[0][rd_ptr_r[0]];
    assign overflow       = overflow_r;

endmodule

// File: tb/tb_umi_priority_merge.sv
// Self-checking bench for umi_priority_merge: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_umi_priority_merge;

    localparam int AW_P     = 64;
    localparam int UW_P     = 64;
    localparam int DEPTH_P  = 4;
    localparam int STARVE_P = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          umi0_in_valid = 1'b0;
    logic [63:0]   umi0_in_packet = 64'd0;
    logic          umi0_in_full;
    logic          umi1_in_valid = 1'b0;
    logic [63:0]   umi1_in_packet = 64'd0;
    logic          umi1_in_full;
    logic          umi_out_valid;
    logic [63:0]   umi_out_packet;
    logic          umi_out_ready = 1'b0;
    logic [1:0]    overflow;

    umi_priority_merge #(
        .AW(AW_P), .UW(UW_P), .DEPTH(DEPTH_P), .STARVE(STARVE_P)
    ) dut (
        .clk(clk), .reset(reset),
        .umi0_in_valid(umi0_in_valid), .umi0_in_packet(umi0_in_packet), .umi0_in_full(umi0_in_full),
        .umi1_in_valid(umi1_in_valid), .umi1_in_packet(umi1_in_packet), .umi1_in_full(umi1_in_full),
        .umi_out_valid(umi_out_valid), .umi_out_packet(umi_out_packet), .umi_out_ready(umi_out_ready),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] out_log[$];
    int          starve = 0;
    int          held = -1;
    logic [1:0]  ovf = 2'b00;
    bit          started = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input bit rst, input bit v0, input logic [63:0] p0,
                        input bit v1, input logic [63:0] p1, input bit rdy);
        int sel;
        bit exp_valid, acc, pre_empty1, full0, full1;
        @(negedge clk);
        reset = rst;
        umi0_in_valid = v0; umi0_in_packet = p0;
        umi1_in_valid = v1; umi1_in_packet = p1;
        umi_out_ready = rdy;
        #1;
        exp_valid = (q0.size() != 0) || (q1.size() != 0);
        if (held >= 0) sel = held;
        else if ((q1.size() != 0) && ((q0.size() == 0) || (starve == STARVE_P))) sel = 1;
        else sel = 0;
        full0 = (q0.size() == DEPTH_P);
        full1 = (q1.size() == DEPTH_P);
        if (started) begin
            check_eq("valid", {63'd0, umi_out_valid}, {63'd0, exp_valid});
            if (exp_valid) check_eq("packet", umi_out_packet, (sel == 1) ? q1[0] : q0[0]);
            check_eq("full0", {63'd0, umi0_in_full}, {63'd0, full0});
            check_eq("full1", {63'd0, umi1_in_full}, {63'd0, full1});
            check_eq("overflow", {62'd0, overflow}, {62'd0, ovf});
        end
        if (!rst && umi_out_valid && rdy) out_log.push_back(umi_out_packet);
        if (rst) begin
            q0.delete(); q1.delete();
            starve = 0; held = -1; ovf = 2'b00; started = 1'b1;
            return;
        end
        acc = exp_valid && rdy;
        pre_empty1 = (q1.size() == 0);
        if (v0 && full0) ovf[0] = 1'b1;
        if (v1 && full1) ovf[1] = 1'b1;
        if (acc) begin
            if (sel == 1) void'(q1.pop_front());
            else void'(q0.pop_front());
        end
        if (v0 && !full0) q0.push_back(p0);
        if (v1 && !full1) q1.push_back(p1);
        if (pre_empty1) starve = 0;
        else if (acc && sel == 1) starve = 0;
        else if (acc && starve < STARVE_P) starve++;
        if (exp_valid && !rdy) held = sel;
        else if (acc) held = -1;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 64'd0, 1'b0, 64'd0, rdy);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        idle(1'b0);
        out_log.delete();
    endtask

    task automatic check_log(input string tag, input logic [63:0] exp[$]);
        check_eq({tag, "_len"}, 64'(out_log.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < out_log.size(); i++)
            check_eq(tag, out_log[i], exp[i]);
    endtask

    initial begin
        logic [63:0] exp[$];
        bit rst, v0, v1, rdy;

        // Reset state
        do_reset();
        check_eq("rst_valid", {63'd0, umi_out_valid}, 64'd0);
        check_eq("rst_ovf", {62'd0, overflow}, 64'd0);

        // Single packet
        step(1'b0, 1'b1, 64'hA5, 1'b0, 64'd0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check_eq("single_drop", {63'd0, umi_out_valid}, 64'd0);
        exp = {64'hA5};
        check_log("single", exp);

        // Priority order
        do_reset();
        step(1'b0, 1'b1, 64'hA0, 1'b1, 64'hB0, 1'b0);
        step(1'b0, 1'b1, 64'hA1, 1'b1, 64'hB1, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        exp = {64'hA0, 64'hA1, 64'hB0, 64'hB1};
        check_log("prio", exp);

        // Starvation limit
        do_reset();
        step(1'b0, 1'b1, 64'hA0, 1'b1, 64'hB0, 1'b0);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 64'hA0 + 64'(i), 1'b0, 64'd0, 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1);
        exp = {64'hA0, 64'hA1, 64'hB0, 64'hA2, 64'hA3, 64'hA4, 64'hA5};
        check_log("starve", exp);

        // Stall / lock
        do_reset();
        step(1'b0, 1'b0, 64'd0, 1'b1, 64'hB0, 1'b0);
        step(1'b0, 1'b1, 64'hA0, 1'b0, 64'd0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check_eq("lock_hold", umi_out_packet, 64'hB0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        exp = {64'hB0, 64'hA0};
        check_log("lock", exp);

        // Full / overflow
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 64'hC0 + 64'(i), 1'b0, 64'd0, 1'b0);
        idle(1'b0);
        check_eq("full_flag", {63'd0, umi0_in_full}, 64'd1);
        check_eq("ovf_bit0", {62'd0, overflow}, 64'd1);
        for (int i = 0; i < 6; i++) idle(1'b1);
        exp = {64'hC0, 64'hC1, 64'hC2, 64'hC3};
        check_log("drain", exp);

        // Reset mid-operation
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 64'hD0 + 64'(i), 1'b1, 64'hE0 + 64'(i), 1'b0);
        step(1'b1, 1'b1, 64'hDD, 1'b1, 64'hEE, 1'b0);
        out_log.delete();
        idle(1'b1);
        check_eq("midrst_valid", {63'd0, umi_out_valid}, 64'd0);
        check_eq("midrst_full", {62'd0, umi1_in_full, umi0_in_full}, 64'd0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check_eq("midrst_stale", 64'(out_log.size()), 64'd0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (q0.size() == DEPTH_P) v0 = ($urandom_range(0, 9) == 0);
            else v0 = ($urandom_range(0, 1) == 1);
            if (q1.size() == DEPTH_P) v1 = ($urandom_range(0, 9) == 0);
            else v1 = ($urandom_range(0, 2) == 0);
            rdy = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
            step(rst, v0, {$urandom, $urandom}, v1, {$urandom, $urandom}, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
